// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit (0), WIDTH data bits MSB first, stop bit (1),
// each bit held for CLK_DIV clocks. Words arrive over a valid/ready handshake accepted only in IDLE.
module serial_frame_tx #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tx_out,
  output logic             busy,
  output logic             done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic [DIV_W-1:0] r_div_cnt, w_div_nxt;
  logic [BIT_W-1:0] r_bit_cnt, w_bit_nxt;
  logic             r_tx, w_tx_nxt;
  logic             r_ready, w_ready_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

  logic w_accept;
  logic w_bit_end;

  assign w_accept  = in_valid && r_ready;
  assign w_bit_end = (r_div_cnt == DIV_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_tx      <= 1'b1;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_div_cnt <= w_div_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_tx      <= w_tx_nxt;
      r_ready   <= w_ready_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_START;
      S_START: if (w_bit_end) w_state_nxt = S_DATA;
      S_DATA:  if (w_bit_end && (r_bit_cnt == BIT_LAST)) w_state_nxt = S_STOP;
      S_STOP:  if (w_bit_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: every signal gets a hold/default value up front so no path through the case infers a latch.
  always_comb begin
    w_shreg_nxt = r_shreg;
    w_div_nxt   = r_div_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_tx_nxt    = r_tx;
    w_ready_nxt = r_ready;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    if (r_state != S_IDLE) begin
      w_div_nxt = w_bit_end ? '0 : r_div_cnt + DIV_W'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_shreg_nxt = in_data;
          w_tx_nxt    = 1'b0;
          w_ready_nxt = 1'b0;
          w_busy_nxt  = 1'b1;
          w_div_nxt   = '0;
          w_bit_nxt   = '0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_tx_nxt    = r_shreg[WIDTH-1];
          w_shreg_nxt = r_shreg << 1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == BIT_LAST) begin
            w_tx_nxt = 1'b1;
          end else begin
            w_bit_nxt   = r_bit_cnt + BIT_W'(1);
            w_tx_nxt    = r_shreg[WIDTH-1];
            w_shreg_nxt = r_shreg << 1;
          end
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_ready_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign in_ready = r_ready;
  assign tx_out   = r_tx;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
